// File: rtl/picomem_mux_1_n.sv
// 1-to-NUM_S PicoMem interconnect: registered decode, unmapped/timeout error responses, saturating error count.
// Latency N+2 (REG_RESP=1) or N+1 (REG_RESP=0) for slave latency N; 2 cycles for unmapped; master stalls until m_ready.
module picomem_mux_1_n #(
    parameter int                   NUM_S          = 4,
    parameter logic [NUM_S*32-1:0]  ADDR_BASE      = {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_S*32-1:0]  ADDR_MASK      = {4{32'hC000_0000}},
    parameter int                   TIMEOUT_CYCLES = 255,
    parameter logic [31:0]          ERR_RDATA      = 32'hDEAD_BEEF,
    parameter bit                   REG_RESP       = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m_valid,
    output logic                m_ready,
    input  logic [31:0]         m_addr,
    input  logic [31:0]         m_wdata,
    input  logic [3:0]          m_wstrb,
    output logic [31:0]         m_rdata,
    output logic [NUM_S-1:0]    s_valid,
    input  logic [NUM_S-1:0]    s_ready,
    output logic [31:0]         s_addr,
    output logic [31:0]         s_wdata,
    output logic [3:0]          s_wstrb,
    input  logic [NUM_S*32-1:0] s_rdata,
    output logic                err_unmapped,
    output logic                err_timeout,
    output logic [15:0]         err_count
);
    localparam int SEL_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RESP, ST_ERR} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               to_err_q, to_err_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_idx;
    logic [31:0]        sel_rdata;
    logic               sel_ready;
    logic               timeout_hit;

    assign s_addr    = m_addr;
    assign s_wdata   = m_wdata;
    assign s_wstrb   = m_wstrb;
    assign err_count = err_cnt_q;

    // Scan from the top down so the lowest matching slot is the last to assign.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if ((m_addr & ADDR_MASK[i*32 +: 32]) == (ADDR_BASE[i*32 +: 32] & ADDR_MASK[i*32 +: 32])) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            if (SEL_W'(i) == sel_q) begin
                sel_rdata = s_rdata[i*32 +: 32];
                sel_ready = s_ready[i];
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            to_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            to_err_q  <= to_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        to_err_d  = to_err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m_valid) begin
                    cnt_d = '0;
                    if (dec_hit) begin
                        state_d = ST_ACTIVE;
                        sel_d   = dec_idx;
                    end else begin
                        state_d  = ST_ERR;
                        to_err_d = 1'b0;
                        rdata_d  = ERR_RDATA;
                    end
                end
            end
            ST_ACTIVE: begin
                cnt_d = cnt_q + 1'b1;
                // Abort beats ready, and ready beats a coincident timeout.
                if (!m_valid) begin
                    state_d = ST_IDLE;
                end else if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = REG_RESP ? ST_RESP : ST_IDLE;
                end else if (timeout_hit) begin
                    state_d  = ST_ERR;
                    to_err_d = 1'b1;
                    rdata_d  = ERR_RDATA;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR: begin
                state_d = ST_IDLE;
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_valid      = '0;
        m_ready      = 1'b0;
        m_rdata      = rdata_q;
        err_unmapped = 1'b0;
        err_timeout  = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                for (int i = 0; i < NUM_S; i++) begin
                    s_valid[i] = m_valid && (SEL_W'(i) == sel_q);
                end
                if (!REG_RESP && m_valid && sel_ready) begin
                    m_ready = 1'b1;
                    m_rdata = sel_rdata;
                end
            end
            ST_RESP: m_ready = 1'b1;
            ST_ERR: begin
                m_ready      = 1'b1;
                err_unmapped = !to_err_q;
                err_timeout  = to_err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_picomem_mux_1_n.sv
// Bench for picomem_mux_1_n: registered and pass-through instances sharing one master/slave model.
module tb_picomem_mux_1_n;
    localparam int NS = 3;
    localparam int TO = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    // Slot1 overlaps slot0 on 0x0xxx_xxxx; 0xCxxx_xxxx is unmapped.
    localparam logic [31:0] TB_BASE [NS] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000};
    localparam logic [31:0] TB_MASK [NS] = '{32'hC000_0000, 32'h8000_0000, 32'hC000_0000};
    localparam logic [NS*32-1:0] P_BASE = {TB_BASE[2], TB_BASE[1], TB_BASE[0]};
    localparam logic [NS*32-1:0] P_MASK = {TB_MASK[2], TB_MASK[1], TB_MASK[0]};

    logic clk = 1'b0;
    logic reset;
    logic cur;
    logic m_valid;
    logic [31:0] m_addr, m_wdata;
    logic [3:0] m_wstrb;
    logic [NS-1:0] s_ready;
    logic [NS*32-1:0] s_rdata;

    logic m_ready_w [2];
    logic [31:0] m_rdata_w [2];
    logic [NS-1:0] s_valid_w [2];
    logic [31:0] s_addr_w [2];
    logic [31:0] s_wdata_w [2];
    logic [3:0] s_wstrb_w [2];
    logic eu_w [2];
    logic et_w [2];
    logic [15:0] ec_w [2];

    int n_checks = 0;
    int n_errors = 0;
    int exp_ec [2];

    always #5 clk = ~clk;

    picomem_mux_1_n #(.NUM_S(NS), .ADDR_BASE(P_BASE), .ADDR_MASK(P_MASK),
        .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR_DATA), .REG_RESP(1'b1)) u_reg (
        .clk(clk), .reset(reset), .m_valid(m_valid & ~cur), .m_ready(m_ready_w[0]),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata_w[0]),
        .s_valid(s_valid_w[0]), .s_ready(s_ready), .s_addr(s_addr_w[0]), .s_wdata(s_wdata_w[0]),
        .s_wstrb(s_wstrb_w[0]), .s_rdata(s_rdata), .err_unmapped(eu_w[0]),
        .err_timeout(et_w[0]), .err_count(ec_w[0]));

    picomem_mux_1_n #(.NUM_S(NS), .ADDR_BASE(P_BASE), .ADDR_MASK(P_MASK),
        .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR_DATA), .REG_RESP(1'b0)) u_comb (
        .clk(clk), .reset(reset), .m_valid(m_valid & cur), .m_ready(m_ready_w[1]),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata_w[1]),
        .s_valid(s_valid_w[1]), .s_ready(s_ready), .s_addr(s_addr_w[1]), .s_wdata(s_wdata_w[1]),
        .s_wstrb(s_wstrb_w[1]), .s_rdata(s_rdata), .err_unmapped(eu_w[1]),
        .err_timeout(et_w[1]), .err_count(ec_w[1]));

    logic m_ready, eu, et;
    logic [31:0] m_rdata, s_addr, s_wdata;
    logic [3:0] s_wstrb;
    logic [NS-1:0] s_valid;
    logic [15:0] ec;
    assign m_ready = m_ready_w[cur];
    assign m_rdata = m_rdata_w[cur];
    assign s_valid = s_valid_w[cur];
    assign s_addr  = s_addr_w[cur];
    assign s_wdata = s_wdata_w[cur];
    assign s_wstrb = s_wstrb_w[cur];
    assign eu      = eu_w[cur];
    assign et      = et_w[cur];
    assign ec      = ec_w[cur];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, cur, $time, got, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & TB_MASK[i]) == (TB_BASE[i] & TB_MASK[i])) return i;
        end
        return -1;
    endfunction

    // Starts and ends on a falling edge. lat = slave wait in s_valid cycles, 0 = never ready.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wd,
                           input int lat, input bit late);
        int sel, act, cyc, nact, exp_cyc;
        logic [31:0] exp_data;
        logic [NS-1:0] exp_sv, one;
        bit err_to, done;
        one = 1;
        sel = ref_decode(addr);
        for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
        err_to = (sel >= 0) && (lat == 0 || lat > TO);
        exp_data = (sel < 0 || err_to) ? ERR_DATA : s_rdata[sel*32 +: 32];
        nact = err_to ? TO : lat;
        if (sel < 0) exp_cyc = 2;
        else if (err_to) exp_cyc = TO + 2;
        else exp_cyc = lat + (cur ? 1 : 2);
        s_ready = '0;
        for (int i = 0; i < NS; i++) if (i != sel) s_ready[i] = 1'($urandom_range(0, 1));
        m_addr = addr; m_wstrb = wstrb; m_wdata = wd; m_valid = 1'b1;
        act = 0; done = 1'b0; cyc = 1;
        while (!done && cyc <= 40) begin
            #1;
            exp_sv = (sel >= 0 && cyc >= 2 && cyc < 2 + nact) ? (one << sel) : '0;
            check_eq("s_valid", s_valid, exp_sv);
            check_eq("s_bus", {s_addr, s_wstrb, s_wdata}, {addr, wstrb, wd});
            if (sel >= 0) begin
                if (s_valid[sel]) act++;
                s_ready[sel] = (lat != 0) && (act >= lat);
            end
            #1;
            check_eq("err_pulse", {eu, et}, (cyc == exp_cyc) ? {sel < 0, err_to} : 2'b00);
            if (m_ready) begin
                check_eq("latency", cyc, exp_cyc);
                check_eq("m_rdata", m_rdata, exp_data);
                done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("resp_seen", done, 1'b1);
        m_valid = 1'b0;
        s_ready = '0;
        if (late && sel >= 0) s_ready[sel] = 1'b1;
        if ((sel < 0 || err_to) && exp_ec[cur] < 65535) exp_ec[cur]++;
        repeat (4) begin
            #1;
            check_eq("idle_quiet", {m_ready, eu, et}, 3'b000);
            check_eq("rdata_hold", m_rdata, exp_data);
            @(negedge clk);
        end
        check_eq("err_count", ec, exp_ec[cur]);
        s_ready = '0;
    endtask

    task automatic run_abort(input logic [31:0] addr);
        logic [NS-1:0] one;
        one = 1;
        m_addr = addr; m_wstrb = 4'h0; m_valid = 1'b1; s_ready = '0;
        repeat (3) @(negedge clk);
        #1 check_eq("abort_pre", s_valid, one << ref_decode(addr));
        m_valid = 1'b0;
        #1 check_eq("abort_gate", {s_valid, m_ready}, '0);
        repeat (4) begin
            @(negedge clk);
            #1 check_eq("abort_quiet", {m_ready, eu, et}, 3'b000);
        end
        check_eq("abort_ec", ec, exp_ec[cur]);
        @(negedge clk);
    endtask

    task automatic run_reset_mid(input logic [31:0] addr);
        logic [NS-1:0] one;
        one = 1;
        m_addr = addr; m_wstrb = 4'h0; m_valid = 1'b1; s_ready = '0;
        repeat (3) @(negedge clk);
        #1 check_eq("rst_pre", s_valid, one << ref_decode(addr));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_valid = 1'b0;
        exp_ec[0] = 0;
        exp_ec[1] = 0;
        #1;
        check_eq("rst_sv", {s_valid, m_ready}, '0);
        check_eq("rst_rdata", m_rdata, 32'h0);
        check_eq("rst_ec", {ec_w[0], ec_w[1]}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        reset = 1'b1; cur = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = '0; s_rdata = '0;
        exp_ec[0] = 0; exp_ec[1] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cur = 1'(d);
            #1;
            check_eq("reset_out", {m_ready, s_valid, eu, et}, '0);
            check_eq("reset_rdata", m_rdata, 32'h0);
            check_eq("reset_ec", ec, 16'h0);
        end
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            cur = 1'(d);
            run_txn(32'h4000_0010, 4'b0000, 32'h0, 1, 1'b0);
            run_txn(32'h8000_0004, 4'b0011, 32'hA5A5_5A5A, 2, 1'b0);
            run_txn(32'h0000_1000, 4'b0000, 32'h0, 1, 1'b0);
            run_txn(32'hC000_0000, 4'b0000, 32'h0, 1, 1'b0);
            run_txn(32'h4000_0000, 4'b0000, 32'h0, 0, 1'b1);
            run_txn(32'h0000_0020, 4'b1111, 32'h0BAD_F00D, TO, 1'b0);
            run_abort(32'h8000_0100);
            run_reset_mid(32'h4000_0040);
            run_txn(32'h4000_0010, 4'b0000, 32'h0, 1, 1'b0);
        end

        for (int n = 0; n < 80; n++) begin
            cur = 1'($urandom_range(0, 1));
            lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            run_txn($urandom, 4'($urandom_range(0, 15)), $urandom, lat, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/picomem_mux_1_n.md
Name: picomem_mux_1_n

Overview:
Parametrised 1-master to NUM_S-slave PicoMem interconnect. It is the successor to the fixed 4-way PicoMem mux in the picotiny SoC. It adds a configurable slave count, a registered address decode, an optional registered response stage, unmapped-address error responses, a per-transaction timeout watchdog and a saturating error counter. It sits between the picorv32 memory port (or an upstream mux) and the slave peripherals.

Parameters:
NUM_S, 4, number of slave ports (1..16)
ADDR_BASE, {32'hC000_0000,32'h8000_0000,32'h4000_0000,32'h0000_0000}, NUM_S*32 flattened; slot i is bits [32i+31:32i]
ADDR_MASK, {4{32'hC000_0000}}, NUM_S*32 flattened match masks
TIMEOUT_CYCLES, 255, max cycles the slave may take to assert ready; 0 disables the watchdog
ERR_RDATA, 32'hDEAD_BEEF, read data returned on error responses
REG_RESP, 1, 1 = registered response to the master; 0 = combinational pass-through

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_valid  in  1  master request
m_ready  out  1  master response strobe
m_addr  in  32  master address
m_wdata  in  32  master write data
m_wstrb  in  4  master byte strobes (0 = read)
m_rdata  out  32  master read data
s_valid  out  NUM_S  one-hot slave request
s_ready  in  NUM_S  per-slave ready
s_addr  out  32  broadcast address
s_wdata  out  32  broadcast write data
s_wstrb  out  4  broadcast strobes
s_rdata  in  NUM_S*32  per-slave read data, flattened
err_unmapped  out  1  1-cycle pulse on an unmapped access
err_timeout  out  1  1-cycle pulse on a watchdog expiry
err_count  out  16  saturating count of all errors

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset, including mid-transaction: state returns to IDLE. s_valid=0, m_ready=0, m_rdata=0, err pulses=0, err_count=0, timeout counter=0.
- s_addr, s_wdata and s_wstrb are continuous combinational copies of the master signals. The master holds them stable while m_valid is high.
- Decode: slave i matches when (m_addr & MASK[i]) == (BASE[i] & MASK[i]). The lowest matching index wins. The chosen index is latched into sel_q.
- FSM:
  - IDLE: when m_valid=1 and m_ready=0, go to ACTIVE if there is a match, otherwise go to ERR.
  - ACTIVE: s_valid[sel_q] = m_valid; all other s_valid bits are 0. The timeout counter increments each ACTIVE cycle and clears on entry.
    - s_ready[sel_q]=1 with REG_RESP=1: capture s_rdata[sel_q] and go to RESP. s_valid drops on the next cycle.
    - s_ready[sel_q]=1 with REG_RESP=0: m_ready=1 and m_rdata=s_rdata[sel_q] combinationally in the same cycle, then go to IDLE.
    - Counter reaches TIMEOUT_CYCLES (when nonzero) without ready: go to ERR with err_timeout. s_valid drops in the next cycle.
    - Ready and timeout in the same cycle: ready wins and there is no error.
    - m_valid drops (abort): go to IDLE. s_valid is gated low in the same cycle; no response, no error.
  - RESP: m_ready=1 for exactly 1 cycle with the captured data, then go to IDLE.
  - ERR: m_ready=1 for 1 cycle with m_rdata=ERR_RDATA. Writes are discarded. err_unmapped or err_timeout pulses in this cycle. err_count increments, saturating at 16'hFFFF. Then go to IDLE.
- Outside a response cycle, m_rdata holds its last value and m_ready=0.
- Latency from m_valid rising to m_ready:
  - REG_RESP=1: decode 1 cycle, slave N cycles (N>=1), response 1 cycle, i.e. N+2.
  - REG_RESP=0: N+1.
  - Unmapped access: 2 cycles.
- Back-to-back requests: IDLE accepts a new request on the cycle after m_ready. No request is decoded while m_ready=1.
- An s_ready from a non-selected slave, or arriving after a timeout, is ignored.
- s_valid is never multi-hot.

Test Plan:
- REG_RESP=1, read 0x4000_0010; slave1 ready on its first s_valid cycle with 0x1234_5678 -> s_valid=4'b0010, m_ready on cycle 3 of the request, m_rdata=0x1234_5678, err_count=0.
- Write 0x8000_0004, wstrb=4'b0011, wdata=0xA5A5_5A5A -> slave2 sees the same addr, wdata and wstrb; exactly one m_ready pulse.
- Overlapping masks (slot0 base 0, mask 0; slot1 base 0x4000_0000) with addr 0x4000_0000 -> slot0 selected (lowest index wins).
- NUM_S=2 covering only 0x0000_0000/0x4000_0000 (mask 0xC000_0000); read 0x8000_0000 -> no s_valid, m_ready at cycle 2, m_rdata=0xDEAD_BEEF, err_unmapped pulse, err_count=1.
- TIMEOUT_CYCLES=8 and slave never ready -> s_valid high for 8 cycles, then ERR response with 0xDEAD_BEEF and err_timeout. A late s_ready 3 cycles later causes no second m_ready.
- Assert reset while in ACTIVE -> the next cycle has s_valid=0, m_ready=0, err_count=0. A fresh read completes normally. Repeat with REG_RESP=0, where m_ready is in the same cycle as s_ready.
